// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: latches one instruction from MEM, drives the GPR write port and
// commit/exception trace info, and generates flush on exception/ertn and halt on invalid instructions.
module wb_commit_stage #(
  parameter logic [5:0]  INE_ECODE   = 6'h0D,
  parameter bit          HALT_ON_INV = 1'b1,
  parameter int unsigned CNT_W       = 64
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             mem_valid,
  output logic             wb_allowin,
  input  logic [31:0]      mem_pc,
  input  logic [31:0]      mem_inst,
  input  logic             mem_inv,
  input  logic             mem_ex,
  input  logic [5:0]       mem_ecode,
  input  logic [8:0]       mem_esubcode,
  input  logic             mem_ertn,
  input  logic             mem_rf_we,
  input  logic [4:0]       mem_rf_waddr,
  input  logic [31:0]      mem_rf_wdata,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             commit_valid,
  output logic [31:0]      commit_pc,
  output logic [31:0]      commit_inst,
  output logic             commit_inv,
  output logic             commit_ex,
  output logic             commit_ertn,
  output logic [5:0]       commit_ecode,
  output logic [8:0]       commit_esubcode,
  output logic [31:0]      ex_pc,
  output logic             flush,
  output logic             halt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_t;

  state_t           state_q;
  logic             wb_valid;
  logic [31:0]      wb_pc;
  logic [31:0]      wb_inst;
  logic             wb_inv;
  logic             wb_ex;
  logic [5:0]       wb_ecode;
  logic [8:0]       wb_esubcode;
  logic             wb_ertn;
  logic             wb_rf_we;
  logic [4:0]       wb_rf_waddr;
  logic [31:0]      wb_rf_wdata;
  logic [31:0]      ex_pc_q;
  logic [CNT_W-1:0] instret_q;
  logic             ex_eff;
  logic             accept;

  // Commit view is decoded straight from the WB registers; an earlier exception outranks invalid decode.
  always_comb begin
    ex_eff          = wb_ex | wb_inv;
    wb_allowin      = (state_q == S_RUN);
    halt            = (state_q == S_HALT);
    commit_valid    = wb_valid;
    commit_pc       = wb_pc;
    commit_inst     = wb_inst;
    commit_inv      = wb_valid & wb_inv;
    commit_ex       = wb_valid & ex_eff;
    commit_ertn     = wb_valid & wb_ertn & ~ex_eff;
    commit_ecode    = 6'd0;
    commit_esubcode = 9'd0;
    if (commit_ex) begin
      commit_ecode    = wb_ex ? wb_ecode : INE_ECODE;
      commit_esubcode = wb_ex ? wb_esubcode : 9'd0;
    end
    rf_we    = wb_valid & wb_rf_we & ~ex_eff;
    rf_waddr = wb_rf_waddr;
    rf_wdata = wb_rf_wdata;
    ex_pc    = commit_ex ? wb_pc : ex_pc_q;
    flush    = commit_ex | commit_ertn;
    accept   = mem_valid & wb_allowin & ~flush;
    instret  = instret_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RUN;
      wb_valid    <= 1'b0;
      wb_pc       <= 32'd0;
      wb_inst     <= 32'd0;
      wb_inv      <= 1'b0;
      wb_ex       <= 1'b0;
      wb_ecode    <= 6'd0;
      wb_esubcode <= 9'd0;
      wb_ertn     <= 1'b0;
      wb_rf_we    <= 1'b0;
      wb_rf_waddr <= 5'd0;
      wb_rf_wdata <= 32'd0;
      ex_pc_q     <= 32'd0;
      instret_q   <= '0;
    end else begin
      wb_valid <= accept;
      if (accept) begin
        wb_pc       <= mem_pc;
        wb_inst     <= mem_inst;
        wb_inv      <= mem_inv;
        wb_ex       <= mem_ex;
        wb_ecode    <= mem_ecode;
        wb_esubcode <= mem_esubcode;
        wb_ertn     <= mem_ertn;
        wb_rf_we    <= mem_rf_we;
        wb_rf_waddr <= mem_rf_waddr;
        wb_rf_wdata <= mem_rf_wdata;
      end
      if (commit_ex) ex_pc_q <= wb_pc;
      if (wb_valid && !ex_eff) instret_q <= instret_q + CNT_W'(1);
      // FLUSH lasts one cycle; HALT is left only through reset.
      unique case (state_q)
        S_RUN: begin
          if (flush) state_q <= (commit_inv && HALT_ON_INV) ? S_HALT : S_FLUSH;
        end
        S_FLUSH: state_q <= S_RUN;
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RUN;
      endcase
    end
  end

endmodule
